// File: rtl/debounce_pkg.sv
// Shared types and constants for the key debouncer.
// The optional press counter is enabled by defining DEBOUNCE_PRESS_CNT_EN.
package debounce_pkg;

  // Number of flops between the raw key and the debounce filter.
  localparam int SYNC_STAGES = 2;

  // Filter state: two stable levels and one "waiting to confirm" state for each.
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_e;

endpackage

// File: rtl/key_debounce_dff_sync2.sv
// Multi-flop synchroniser (depth SYNC_STAGES) that brings the raw key input into the clk domain.
// All flops clear to 0 on the asynchronous reset r.
module sync2
  import debounce_pkg::*;
(
  input  logic clk,
  input  logic r,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff_q;

  // Shift the input through the flop chain; the last stage is the safe output.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = ff_q[SYNC_STAGES-1];

endmodule

// File: rtl/key_debounce_dff.sv
// Push-button / switch debouncer: synchronise, filter with a stable-time
// counter, and emit a clean level (q/qn) plus one-cycle edge pulses.
// Optional feature macro: DEBOUNCE_PRESS_CNT_EN adds an 8-bit press_cnt
// output that counts key_rise pulses since reset (wraps 255 -> 0).
module key_debounce_dff
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_W         = 10
) (
  input  logic       clk,
  input  logic       r,
  input  logic       key_in,
  output logic       q,
  output logic       qn,
  output logic       key_rise,
`ifdef DEBOUNCE_PRESS_CNT_EN
  output logic       key_fall,
  output logic [7:0] press_cnt
`else
  output logic       key_fall
`endif
);

  // Terminal count: the synchronised input has disagreed with q long enough.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             key_s2;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  sync2 u_sync (
    .clk (clk),
    .r   (r),
    .d   (key_in),
    .q   (key_s2)
  );

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next-state logic: a change is accepted only after CNT_LAST+1 consecutive
  // samples disagree with the current level; any agreeing sample restarts it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE_LOW: begin
        if (key_s2) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!key_s2) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          q_d     = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!key_s2) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (key_s2) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          q_d     = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign q        = q_q;
  assign qn       = ~q_q;
  assign key_rise = rise_q;
  assign key_fall = fall_q;

`ifdef DEBOUNCE_PRESS_CNT_EN
  logic [7:0] press_q;
  logic [7:0] press_d;

  // Count accepted presses; bumps on the same edge that registers key_rise.
  always_comb begin
    press_d = press_q + {7'd0, rise_d};
  end

  // Press counter register.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      press_q <= '0;
    end else begin
      press_q <= press_d;
    end
  end

  assign press_cnt = press_q;
`endif

endmodule
